// File: rtl/act_mem_rd_seq_pkg.sv
// Shared accelerator definitions for the activation-memory read sequencer.
// Holds the sequencer state encoding and the default precision bounds.
package act_mem_rd_seq_pkg;

    localparam int unsigned PMAX_DEFAULT = 8;
    localparam int unsigned PMIN_DEFAULT = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

endpackage

// File: rtl/act_rd_fifo2.sv
// Two-entry FIFO with occupancy count; head entry is presented combinationally.
module act_rd_fifo2 #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        head    = mem_q[rd_ptr_q];
        count   = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/act_mem_rd_seq.sv
// Read sequencer: issues up to num_words reads to the activation memory wrapper,
// buffers the returned words in a 2-entry FIFO and streams them out with valid/ready.
module act_mem_rd_seq
    import act_mem_rd_seq_pkg::*;
#(
    parameter int unsigned PMAX        = PMAX_DEFAULT,
    parameter int unsigned PMIN        = PMIN_DEFAULT,
    parameter int unsigned NUM_BANKS   = PMAX / PMIN,
    parameter int unsigned DATA_WIDTH  = PMAX * NUM_BANKS,
    parameter int unsigned ADDR_WIDTH  = $clog2(NUM_BANKS),
    parameter int unsigned PMODE_WIDTH = $clog2(NUM_BANKS),
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PMODE_WIDTH-1:0] precision_mode,
    input  logic [CNT_WIDTH-1:0]   num_words,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [PMODE_WIDTH-1:0] mem_precision_mode,
    input  logic [DATA_WIDTH-1:0]  mem_data,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last
);

    state_e                 state_q, state_d;
    logic [PMODE_WIDTH-1:0] mode_q, mode_d;
    logic [CNT_WIDTH-1:0]   total_q, total_d;
    logic [CNT_WIDTH-1:0]   issued_q, issued_d;
    logic                   pend_q, pend_last_q;
    logic                   drain_seen_q;
    logic                   issue;
    logic                   issue_last;
    logic                   pop;
    logic [1:0]             fifo_count;
    logic [DATA_WIDTH:0]    fifo_head;
    logic [ADDR_WIDTH-1:0]  addr_mask;

    act_rd_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pend_q),
        .push_data ({pend_last_q, mem_data}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_comb begin
        // Address wraps at 2^min(mode, ADDR_WIDTH); bit i survives only when i < mode.
        addr_mask = '0;
        for (int unsigned i = 0; i < ADDR_WIDTH; i++) begin
            addr_mask[i] = (i < 32'(mode_q));
        end
        mem_addr           = issued_q[ADDR_WIDTH-1:0] & addr_mask;
        mem_precision_mode = mode_q;
        busy               = (state_q != StIdle);
        out_valid          = (fifo_count != 2'd0);
        out_data           = fifo_head[DATA_WIDTH-1:0];
        out_last           = fifo_head[DATA_WIDTH] & out_valid;
        pop                = out_valid && out_ready;
        issue_last         = (issued_q == (total_q - 1'b1));
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        total_d  = total_q;
        issued_d = issued_q;
        issue    = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d   = precision_mode;
                    total_d  = num_words;
                    issued_d = '0;
                    state_d  = (num_words != '0) ? StRun : StDrain;
                end
            end
            StRun: begin
                issue = ({1'b0, fifo_count} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop});
                if (issue) begin
                    issued_d = issued_q + 1'b1;
                    if (issue_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Drain spans at least two cycles, so done trails the final pop by one cycle.
                if (drain_seen_q && !pend_q && (fifo_count == 2'd0)) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            mode_q       <= '0;
            total_q      <= '0;
            issued_q     <= '0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            drain_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            total_q      <= total_d;
            issued_q     <= issued_d;
            pend_q       <= issue;
            pend_last_q  <= issue && issue_last;
            drain_seen_q <= (state_q == StDrain);
        end
    end

endmodule
